stutter_scheduler: RTL

Sequencing controller for the asynchronous two-copy hyperproperty harness: latches the secret once, then decides each cycle whether the source and target codeblocks advance or stutter. It enforces alignment at observation points, bounded stutter fairness, and a step budget. It sits between the model checker's free inputs and the two codeblock instances, replacing ad-hoc clock gating with explicit per-copy step enables.

---
 rtl/stutter_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/stutter_scheduler.sv
// Step scheduler for the two-copy hyperproperty harness: latches the secret once, then
// issues per-copy step enables that honour observation-point alignment, stutter fairness and a step budget.
module stutter_scheduler #(
  parameter int MAX_STUTTER = 4,
  parameter int SCNT_W      = 3,
  parameter int MAX_STEPS   = 64,
  parameter int STEP_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       secret_in,
  input  logic [1:0] choice,
  input  logic       st_src,
  input  logic       st_tar,
  input  logic       pub_src,
  input  logic       pub_tar,
  output logic       secret_v,
  output logic       en_src,
  output logic       en_tar,
  output logic       aligned,
  output logic       mismatch,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [SCNT_W-1:0] STALL_MAX = SCNT_W'(MAX_STUTTER);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  state_t             state, state_nx;
  logic [SCNT_W-1:0]  stall_src, stall_tar, stall_src_nx, stall_tar_nx;
  logic [STEP_W-1:0]  step_cnt;
  logic               run, meet, hold_src, hold_tar, force_src, force_tar;

  always_comb begin
    run       = (state == RUN);
    meet      = st_src & st_tar;
    hold_src  = st_src & ~st_tar;
    hold_tar  = st_tar & ~st_src;
    force_src = (stall_src == STALL_MAX);
    force_tar = (stall_tar == STALL_MAX);
    en_src    = 1'b0;
    en_tar    = 1'b0;
    if (run) begin
      if (meet) begin
        en_src = 1'b1;
        en_tar = 1'b1;
      end else if (choice == 2'b11 && !hold_src && !hold_tar && !force_src && !force_tar) begin
        // A request to stall both copies would freeze the system; step both instead.
        en_src = 1'b1;
        en_tar = 1'b1;
      end else begin
        en_src = hold_src ? 1'b0 : (force_src ? 1'b1 : ~choice[0]);
        en_tar = hold_tar ? 1'b0 : (force_tar ? 1'b1 : ~choice[1]);
      end
    end
  end

  // Stall counters only track choice-induced stalls; an alignment hold resets them.
  always_comb begin
    stall_src_nx = '0;
    stall_tar_nx = '0;
    if (run) begin
      if (!en_src && !hold_src && !force_src) stall_src_nx = stall_src + 1'b1;
      else if (!en_src && !hold_src)          stall_src_nx = stall_src;
      if (!en_tar && !hold_tar && !force_tar) stall_tar_nx = stall_tar + 1'b1;
      else if (!en_tar && !hold_tar)          stall_tar_nx = stall_tar;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = LATCH;
      LATCH: state_nx = RUN;
      RUN:   if (mismatch || step_cnt == STEP_LAST) state_nx = DONE;
      DONE:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      secret_v  <= 1'b0;
      aligned   <= 1'b0;
      mismatch  <= 1'b0;
      stall_src <= '0;
      stall_tar <= '0;
      step_cnt  <= '0;
    end else begin
      state     <= state_nx;
      stall_src <= stall_src_nx;
      stall_tar <= stall_tar_nx;
      aligned   <= run & meet;
      if (state == LATCH) secret_v <= secret_in;
      if (run && meet && (pub_src != pub_tar)) mismatch <= 1'b1;
      if (run) step_cnt <= step_cnt + 1'b1;
      else     step_cnt <= '0;
    end
  end

endmodule
